mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage load/store engine. It consumes the memory control word produced by instruction decode (mem_read, mem_write, mem_size, load_signed) plus the ALU effective address and store data. It drives a valid/ready data-memory bus with byte enables and returns the aligned, sign- or zero-extended load result. While an access is outstanding it stalls the pipeline, and it flags misalignment and bus timeout.

Parameters:
ADDR_W, 32, bus address width; the effective address input is always 32 bits and the low ADDR_W bits drive the bus.
TIMEOUT_CYCLES, 255, max cycles spent in REQ+RESP before the bus-error pulse; 0 disables the timeout.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  load request from MEM-stage control
mem_write  in  1  store request from MEM-stage control
mem_size  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
load_signed  in  1  1 sign-extend, 0 zero-extend; ignored for word
kill  in  1  squash the MEM-stage op; sampled only in IDLE
addr  in  32  effective address (ALU result)
store_data  in  32  rt value to be stored
stall  out  1  hold IF..MEM stages
ld_data  out  32  extended load result, valid when done=1 and load
done  out  1  one-cycle pulse when the access completes
misalign  out  1  one-cycle pulse on an unaligned access
bus_err  out  1  one-cycle pulse on timeout
bus_valid  out  1  request valid
bus_ready  in  1  request accepted
bus_we  out  1  1 write, 0 read
bus_addr  out  ADDR_W  word-aligned address (addr[1:0] forced to 00)
bus_be  out  4  byte enables, little-endian
bus_wdata  out  32  lane-replicated store data
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data word

Behaviour:
- Reset: state=IDLE. stall, done, misalign, bus_err, bus_valid and bus_we are 0. ld_data, bus_addr, bus_be and bus_wdata are 0. Timeout counter is 0.
- Request: req = (mem_read | mem_write) & ~kill. If both mem_read and mem_write are set, the write wins.
- Misalignment:
  - Word access with addr[1:0] != 0, or half access with addr[0] != 0.
  - Checked in IDLE. Pulse misalign in the same cycle (combinational), stall=0, no bus access, state stays IDLE.
- States:
  - IDLE: on an aligned req, register addr/be/wdata/we/size/signed/lane and go to REQ. stall=1 combinationally in this cycle.
  - REQ: bus_valid=1 with all bus fields held stable. On bus_ready: a write goes to DONE, a read goes to RESP.
  - RESP: on bus_rvalid, capture the extracted and extended data into ld_data, then go to DONE. bus_valid=0.
  - DONE: done=1, stall=0, go to IDLE. The pipeline advances at the end of this cycle, so the next IDLE cycle sees the next instruction.
- stall: 1 in IDLE-with-aligned-req, REQ and RESP; 0 otherwise.
- Latency: minimum 3 cycles for a store (IDLE, REQ, DONE). Minimum 4 cycles for a load (IDLE, REQ, RESP with rvalid, DONE).
- Byte enables and write data:
  - Byte: be = 4'b0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{store_data[15:0]}}.
  - Word: be = 1111; wdata = store_data.
- Load extraction:
  - Byte: lane = rdata[8*addr[1:0] +: 8].
  - Half: lane = rdata[16*addr[1] +: 16].
  - Extend to 32 bits using load_signed. Word loads pass rdata through unchanged.
- Timeout:
  - The counter clears on entry to REQ and increments in REQ and RESP.
  - When it reaches TIMEOUT_CYCLES (nonzero), pulse bus_err, drop bus_valid and go to IDLE (not DONE). stall deasserts in that cycle and ld_data keeps its old value.
- kill: ignored once the FSM has left IDLE. An issued bus transaction always completes.
- bus_rvalid outside RESP is ignored. bus_ready outside REQ is ignored.
- Asynchronous reset mid-transaction returns to IDLE immediately with all outputs at reset values. The bus must tolerate an abandoned request.

Decomposition:
- Shared package/include: MEM_SIZE_WORD/HALF/BYTE encodings (00/01/10), FSM state encodings, and the TIMEOUT_CYCLES default.
- One natural sub-module: mem_lane_align. It is purely combinational: be, wdata replication, load extraction and extension. It is unit-testable on its own.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, bus_ready=1 in the first REQ cycle -> bus_be=1111, bus_wdata=0xDEADBEEF, bus_addr=0x100. done pulses in cycle 3; stall is high for cycles 1-2.
- LB addr=0x103, rdata=0x80FFFFFF, load_signed=1 -> ld_data=0xFFFFFF80. The same access with LBU -> 0x00000080; bus_be=1000.
- SH addr=0x202, data=0x0000ABCD -> be=1100, wdata=0xABCDABCD. A following LH at 0x202 with rdata=0xABCD1234 -> ld_data=0xFFFFABCD.
- LW addr=0x101 -> misalign pulses in the same cycle, stall=0, bus_valid stays 0, no done.
- LW with bus_ready held low for 5 cycles then rvalid 3 cycles later -> stall stays high throughout, exactly one done, ld_data=rdata.
- TIMEOUT_CYCLES=4, bus_ready stuck low -> bus_err pulses 4 cycles after REQ entry and the FSM returns to IDLE. Separately, rst_n low mid-REQ -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the MEM-stage load/store engine:
//   - mem_size encodings produced by instruction decode
//   - FSM state encoding of the access sequencer
//   - default bus timeout
//   - lane extension helper used by the load path
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

   // Access size as decoded from the instruction; 2'b11 is reserved and is
   // handled everywhere as a word access.
   localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;

   // Cycles allowed in REQ+RESP before the bus is declared hung.
   localparam int TIMEOUT_CYCLES_DEFAULT = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10,
      ST_DONE = 2'b11
   } mau_state_e;

   // Extend a 16-bit lane to 32 bits; narrower lanes are passed in
   // pre-positioned with their sign bit selected by the caller.
   function automatic logic [31:0] extend16(input logic [15:0] lane,
                                            input logic        sign_bit);
      return {{16{sign_bit}}, lane};
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational lane logic for the load/store engine.
// Store side (driven from the live MEM-stage inputs):
//   st_size, st_lane  : access size and addr[1:0]
//   store_data        : rt value
//   be, wdata         : byte enables and lane-replicated write data
//   misalign          : word not on a 4-byte or half not on a 2-byte boundary
// Load side (driven from the captured access fields):
//   ld_size, ld_lane, ld_signed : captured size, addr[1:0], extension mode
//   rdata             : bus read word
//   ld_ext            : extracted and extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_lane,
   input  logic [31:0] store_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        misalign,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_lane,
   input  logic        ld_signed,
   input  logic [31:0] rdata,
   output logic [31:0] ld_ext
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Store path: the bus sees a full word, so narrow data is replicated into
   // every lane and the byte enables pick the one that matters.
   // NOTE: every output of a combinational block gets a default before the
   // case statement, so no path can leave it unassigned and infer a latch.
   always_comb begin
      be       = 4'b1111;
      wdata    = store_data;
      misalign = 1'b0;
      case (st_size)
         MEM_SIZE_BYTE: begin
            be    = 4'b0001 << st_lane;
            wdata = {4{store_data[7:0]}};
         end
         MEM_SIZE_HALF: begin
            be       = st_lane[1] ? 4'b1100 : 4'b0011;
            wdata    = {2{store_data[15:0]}};
            misalign = st_lane[0];
         end
         default: misalign = |st_lane;
      endcase
   end

   // Load path: pick the addressed lane, then extend it.
   always_comb begin
      case (ld_lane)
         2'd0:    byte_lane = rdata[7:0];
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase
      half_lane = ld_lane[1] ? rdata[31:16] : rdata[15:0];

      ld_ext = rdata;
      case (ld_size)
         MEM_SIZE_BYTE: ld_ext = {{24{ld_signed & byte_lane[7]}}, byte_lane};
         MEM_SIZE_HALF: ld_ext = extend16(half_lane, ld_signed & half_lane[15]);
         default:       ld_ext = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store engine. Takes the decoded memory control word and the
// ALU effective address, runs one access on a valid/ready data bus, and
// returns the aligned, extended load result.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   mem_read, mem_write        : load / store request (write wins if both)
//   mem_size, load_signed      : access size, extension mode for loads
//   kill                       : squash the request (looked at in IDLE only)
//   addr, store_data           : effective address, rt value
//   stall                      : hold IF..MEM while the access is in flight
//   ld_data, done              : load result, one-cycle completion pulse
//   misalign, bus_err          : unaligned-access pulse, bus-timeout pulse
//   bus_valid/ready/we/addr/be/wdata : request channel
//   bus_rvalid, bus_rdata      : read response channel
// -----------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        mem_size,
   input  logic              load_signed,
   input  logic              kill,
   input  logic [31:0]       addr,
   input  logic [31:0]       store_data,
   output logic              stall,
   output logic [31:0]       ld_data,
   output logic              done,
   output logic              misalign,
   output logic              bus_err,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   mau_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [1:0]        lane_q, lane_d;
   logic [31:0]       ld_data_q, ld_data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic        req;
   logic        timeout_hit;
   logic        st_misalign;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_ext;

   mem_lane_align u_lane_align (
      .st_size    (mem_size),
      .st_lane    (addr[1:0]),
      .store_data (store_data),
      .be         (st_be),
      .wdata      (st_wdata),
      .misalign   (st_misalign),
      .ld_size    (size_q),
      .ld_lane    (lane_q),
      .ld_signed  (signed_q),
      .rdata      (bus_rdata),
      .ld_ext     (ld_ext)
   );

   assign req         = (mem_read | mem_write) & ~kill;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      size_d    = size_q;
      signed_d  = signed_q;
      lane_d    = lane_q;
      ld_data_d = ld_data_q;
      cnt_d     = cnt_q;
      stall     = 1'b0;
      done      = 1'b0;
      misalign  = 1'b0;
      bus_err   = 1'b0;
      bus_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (st_misalign) begin
                  // Rejected here: no bus traffic, pipeline not held.
                  misalign = 1'b1;
               end else begin
                  // Stall must rise in this very cycle so the instruction
                  // stays in MEM while the bus access runs.
                  stall    = 1'b1;
                  state_d  = ST_REQ;
                  addr_d   = {addr[ADDR_W-1:2], 2'b00};
                  be_d     = st_be;
                  wdata_d  = st_wdata;
                  we_d     = mem_write;
                  size_d   = mem_size;
                  signed_d = load_signed;
                  lane_d   = addr[1:0];
                  cnt_d    = '0;
               end
            end
         end
         ST_REQ: begin
            if (timeout_hit) begin
               bus_err = 1'b1;
               state_d = ST_IDLE;
            end else begin
               bus_valid = 1'b1;
               stall     = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (bus_ready) state_d = we_q ? ST_DONE : ST_RESP;
            end
         end
         ST_RESP: begin
            if (timeout_hit) begin
               // ld_data deliberately keeps its previous value.
               bus_err = 1'b1;
               state_d = ST_IDLE;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (bus_rvalid) begin
                  ld_data_d = ld_ext;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the values computed before this edge, regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         size_q    <= MEM_SIZE_WORD;
         signed_q  <= 1'b0;
         lane_q    <= '0;
         ld_data_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         size_q    <= size_d;
         signed_q  <= signed_d;
         lane_q    <= lane_d;
         ld_data_q <= ld_data_d;
         cnt_q     <= cnt_d;
      end
   end

   // Request fields come straight from flops so they are stable for the
   // whole REQ phase regardless of what the pipeline presents meanwhile.
   assign bus_addr  = addr_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;
   assign bus_we    = we_q;
   assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write, load_signed, kill;
   logic [1:0]  mem_size;
   logic [31:0] addr, store_data;
   logic        bus_ready, bus_rvalid;
   logic [31:0] bus_rdata;

   // main instance (default timeout)
   logic        stall, done, misalign, bus_err, bus_valid, bus_we;
   logic [31:0] ld_data, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   // short-timeout instance
   logic        to_stall, to_done, to_misalign, to_bus_err, to_bus_valid, to_bus_we;
   logic [31:0] to_ld_data, to_bus_addr, to_bus_wdata;
   logic [3:0]  to_bus_be;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .load_signed(load_signed), .kill(kill), .addr(addr),
      .store_data(store_data), .stall(stall), .ld_data(ld_data), .done(done),
      .misalign(misalign), .bus_err(bus_err), .bus_valid(bus_valid),
      .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .load_signed(load_signed), .kill(kill), .addr(addr),
      .store_data(store_data), .stall(to_stall), .ld_data(to_ld_data), .done(to_done),
      .misalign(to_misalign), .bus_err(to_bus_err), .bus_valid(to_bus_valid),
      .bus_ready(bus_ready), .bus_we(to_bus_we), .bus_addr(to_bus_addr), .bus_be(to_bus_be),
      .bus_wdata(to_bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Advance to just after the next rising edge (start of the next cycle).
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_read = 0; mem_write = 0; kill = 0; load_signed = 0;
      mem_size = 2'b00; bus_ready = 0; bus_rvalid = 0;
   endtask

   // Store with bus_ready in the first REQ cycle; returns REQ-cycle bus
   // fields and the done seen in the third cycle.
   task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            output logic [3:0] be, output logic [31:0] wd,
                            output logic [31:0] ba, output logic we, output logic dn);
      mem_write = 1; mem_size = sz; addr = a; store_data = d; bus_ready = 1;
      @(negedge clk); next_cycle();
      mem_write = 0;
      @(negedge clk); be = bus_be; wd = bus_wdata; ba = bus_addr; we = bus_we;
      next_cycle(); bus_ready = 0;
      @(negedge clk); dn = done;
      next_cycle();
   endtask

   // Load with ready in the first REQ cycle and rvalid in the first RESP cycle.
   task automatic run_load(input logic [1:0] sz, input logic sgn, input logic [31:0] a,
                           input logic [31:0] rd, output logic [3:0] be,
                           output logic [31:0] ba, output logic [31:0] ld, output logic dn);
      mem_read = 1; mem_size = sz; load_signed = sgn; addr = a; bus_ready = 1;
      @(negedge clk); next_cycle();
      mem_read = 0;
      @(negedge clk); be = bus_be; ba = bus_addr;
      next_cycle(); bus_ready = 0; bus_rvalid = 1; bus_rdata = rd;
      @(negedge clk); next_cycle();
      bus_rvalid = 0; bus_rdata = 32'h0;
      @(negedge clk); dn = done; ld = ld_data;
      next_cycle();
   endtask

   task automatic test_reset();
      rst_n = 0; idle_inputs(); addr = 0; store_data = 0; bus_rdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if ({stall, done, misalign, bus_err, bus_valid, bus_we} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                            {stall, done, misalign, bus_err, bus_valid, bus_we}); end
      checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL reset_ld_data: got %h expected 0", ld_data); end
      checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr: got %h expected 0", bus_addr); end
      checks++; if (bus_be !== 4'h0) begin errors++; $display("FAIL reset_bus_be: got %h expected 0", bus_be); end
      checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata: got %h expected 0", bus_wdata); end
      rst_n = 1;
      next_cycle();
   endtask

   task automatic test_store_word();
      mem_write = 1; mem_size = 2'b00; addr = 32'h100; store_data = 32'hDEADBEEF; bus_ready = 1;
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sw_c1_stall: got %b expected 1", stall); end
      checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL sw_c1_valid: got %b expected 0", bus_valid); end
      next_cycle(); mem_write = 0;
      @(negedge clk);
      checks++; if ({stall, bus_valid, bus_we} !== 3'b111) begin errors++; $display("FAIL sw_c2_ctrl: got %b expected 111", {stall, bus_valid, bus_we}); end
      checks++; if (bus_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b expected 1111", bus_be); end
      checks++; if (bus_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", bus_wdata); end
      checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL sw_addr: got %h expected 00000100", bus_addr); end
      next_cycle(); bus_ready = 0;
      @(negedge clk);
      checks++; if ({done, stall, bus_valid} !== 3'b100) begin errors++; $display("FAIL sw_c3_done: got %b expected 100", {done, stall, bus_valid}); end
      next_cycle();
      @(negedge clk);
      checks++; if ({done, stall} !== 2'b00) begin errors++; $display("FAIL sw_c4_idle: got %b expected 00", {done, stall}); end
      next_cycle();
   endtask

   task automatic test_byte_load();
      logic [3:0] be; logic [31:0] ba, ld; logic dn;
      run_load(2'b10, 1'b1, 32'h103, 32'h80FFFFFF, be, ba, ld, dn);
      checks++; if (ld !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h expected ffffff80", ld); end
      checks++; if (dn !== 1'b1) begin errors++; $display("FAIL lb_done: got %b expected 1", dn); end
      run_load(2'b10, 1'b0, 32'h103, 32'h80FFFFFF, be, ba, ld, dn);
      checks++; if (ld !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h expected 00000080", ld); end
      checks++; if (be !== 4'b1000) begin errors++; $display("FAIL lbu_be: got %b expected 1000", be); end
      checks++; if (ba !== 32'h100) begin errors++; $display("FAIL lbu_addr: got %h expected 00000100", ba); end
      run_load(2'b10, 1'b1, 32'h101, 32'h80FF7F00, be, ba, ld, dn);
      checks++; if (ld !== 32'h0000007F) begin errors++; $display("FAIL lb_pos: got %h expected 0000007f", ld); end
      checks++; if (be !== 4'b0010) begin errors++; $display("FAIL lb_pos_be: got %b expected 0010", be); end
   endtask

   task automatic test_half_and_sb();
      logic [3:0] be; logic [31:0] wd, ba, ld; logic we, dn;
      run_store(2'b01, 32'h202, 32'h0000ABCD, be, wd, ba, we, dn);
      checks++; if (be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", be); end
      checks++; if (wd !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", wd); end
      checks++; if (ba !== 32'h200) begin errors++; $display("FAIL sh_addr: got %h expected 00000200", ba); end
      // immediately following load: back-to-back with the store
      run_load(2'b01, 1'b1, 32'h202, 32'hABCD1234, be, ba, ld, dn);
      checks++; if (ld !== 32'hFFFFABCD) begin errors++; $display("FAIL lh: got %h expected ffffabcd", ld); end
      run_load(2'b01, 1'b0, 32'h200, 32'hABCD1234, be, ba, ld, dn);
      checks++; if (ld !== 32'h00001234) begin errors++; $display("FAIL lhu: got %h expected 00001234", ld); end
      checks++; if (be !== 4'b0011) begin errors++; $display("FAIL lhu_be: got %b expected 0011", be); end
      run_store(2'b10, 32'h101, 32'h12345678, be, wd, ba, we, dn);
      checks++; if (be !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b expected 0010", be); end
      checks++; if (wd !== 32'h78787878) begin errors++; $display("FAIL sb_wdata: got %h expected 78787878", wd); end
      checks++; if ({we, dn} !== 2'b11) begin errors++; $display("FAIL sb_we_done: got %b expected 11", {we, dn}); end
      run_load(2'b00, 1'b1, 32'h104, 32'hCAFEF00D, be, ba, ld, dn);
      checks++; if (ld !== 32'hCAFEF00D) begin errors++; $display("FAIL lw: got %h expected cafef00d", ld); end
   endtask

   task automatic test_misalign();
      mem_read = 1; mem_size = 2'b00; addr = 32'h101;
      @(negedge clk);
      checks++; if ({misalign, stall, bus_valid} !== 3'b100) begin errors++; $display("FAIL lw_misalign: got %b expected 100", {misalign, stall, bus_valid}); end
      next_cycle(); mem_read = 0;
      @(negedge clk);
      checks++; if ({misalign, bus_valid, done} !== 3'b000) begin errors++; $display("FAIL lw_misalign_after: got %b expected 000", {misalign, bus_valid, done}); end
      next_cycle();
      mem_write = 1; mem_size = 2'b01; addr = 32'h203;
      @(negedge clk);
      checks++; if ({misalign, stall} !== 2'b10) begin errors++; $display("FAIL sh_misalign: got %b expected 10", {misalign, stall}); end
      next_cycle(); mem_write = 0;
      @(negedge clk);
      checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL sh_misalign_valid: got %b expected 0", bus_valid); end
      next_cycle();
   endtask

   task automatic test_kill_and_priority();
      // squashed request never starts
      mem_read = 1; kill = 1; mem_size = 2'b00; addr = 32'h100;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL kill_stall: got %b expected 0", stall); end
      next_cycle(); mem_read = 0; kill = 0;
      @(negedge clk);
      checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL kill_valid: got %b expected 0", bus_valid); end
      next_cycle();
      // kill after issue is ignored
      mem_read = 1; addr = 32'h108;
      @(negedge clk); next_cycle();
      mem_read = 0; kill = 1; bus_ready = 1;
      @(negedge clk);
      checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL late_kill_valid: got %b expected 1", bus_valid); end
      next_cycle(); bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'h13579BDF;
      @(negedge clk); next_cycle(); bus_rvalid = 0;
      @(negedge clk);
      checks++; if ({done, ld_data} !== {1'b1, 32'h13579BDF}) begin errors++; $display("FAIL late_kill_done: got %b/%h expected 1/13579bdf", done, ld_data); end
      next_cycle(); kill = 0;
      // read and write together: write wins
      mem_read = 1; mem_write = 1; addr = 32'h10C; store_data = 32'h0F0F0F0F; bus_ready = 1;
      @(negedge clk); next_cycle();
      mem_read = 0; mem_write = 0;
      @(negedge clk);
      checks++; if ({bus_valid, bus_we} !== 2'b11) begin errors++; $display("FAIL rw_write_wins: got %b expected 11", {bus_valid, bus_we}); end
      next_cycle(); bus_ready = 0;
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rw_done: got %b expected 1", done); end
      next_cycle();
   endtask

   task automatic test_slow_load();
      int n_done = 0;
      int n_bad  = 0;
      mem_read = 1; mem_size = 2'b00; addr = 32'h300; bus_ready = 0;
      @(negedge clk); if (stall !== 1'b1) n_bad++; if (done) n_done++;
      next_cycle(); mem_read = 0;
      bus_rvalid = 1; bus_rdata = 32'hFFFFFFFF;     // must be ignored in REQ
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); if (!(stall && bus_valid)) n_bad++; if (done) n_done++;
         next_cycle();
      end
      bus_ready = 1; bus_rvalid = 0;
      @(negedge clk); if (!(stall && bus_valid)) n_bad++; if (done) n_done++;
      next_cycle();                                   // now in RESP; ready ignored
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); if (!stall || bus_valid) n_bad++; if (done) n_done++;
         next_cycle();
      end
      bus_rvalid = 1; bus_rdata = 32'h11223344;
      @(negedge clk); if (!stall) n_bad++; if (done) n_done++;
      next_cycle(); bus_rvalid = 0; bus_ready = 0;
      @(negedge clk); if (stall) n_bad++; if (done) n_done++;
      checks++; if (ld_data !== 32'h11223344) begin errors++; $display("FAIL slow_ld_data: got %h expected 11223344", ld_data); end
      next_cycle();
      @(negedge clk); if (done) n_done++;
      next_cycle();
      checks++; if (n_bad !== 0) begin errors++; $display("FAIL slow_stall: got %0d bad cycles expected 0", n_bad); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL slow_done_count: got %0d expected 1", n_done); end
   endtask

   task automatic test_timeout();
      logic [3:0] be; logic [31:0] ba, ld; logic dn;
      rst_n = 0; idle_inputs();
      @(negedge clk); rst_n = 1;
      next_cycle();
      run_load(2'b00, 1'b0, 32'h500, 32'h0BADF00D, be, ba, ld, dn);
      checks++; if (to_ld_data !== 32'h0BADF00D) begin errors++; $display("FAIL to_preload: got %h expected 0badf00d", to_ld_data); end
      mem_write = 1; mem_size = 2'b00; addr = 32'h400; store_data = 32'h55AA55AA; bus_ready = 0;
      @(negedge clk);
      checks++; if (to_stall !== 1'b1) begin errors++; $display("FAIL to_idle_stall: got %b expected 1", to_stall); end
      next_cycle(); mem_write = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if ({to_bus_valid, to_bus_err} !== 2'b10) begin errors++; $display("FAIL to_req_%0d: got %b expected 10", k, {to_bus_valid, to_bus_err}); end
         next_cycle();
      end
      @(negedge clk);
      checks++; if ({to_bus_err, to_bus_valid, to_stall, to_done} !== 4'b1000) begin errors++; $display("FAIL to_pulse: got %b expected 1000", {to_bus_err, to_bus_valid, to_stall, to_done}); end
      next_cycle();
      @(negedge clk);
      checks++; if ({to_bus_err, to_bus_valid, to_done} !== 3'b000) begin errors++; $display("FAIL to_after: got %b expected 000", {to_bus_err, to_bus_valid, to_done}); end
      checks++; if (to_ld_data !== 32'h0BADF00D) begin errors++; $display("FAIL to_ld_keep: got %h expected 0badf00d", to_ld_data); end
      next_cycle();
   endtask

   task automatic test_reset_mid_req();
      // main instance is still waiting in REQ with the 0x400 store
      @(negedge clk);
      checks++; if ({bus_valid, bus_we, stall} !== 3'b111) begin errors++; $display("FAIL mid_req_pre: got %b expected 111", {bus_valid, bus_we, stall}); end
      next_cycle();
      #2 rst_n = 0;
      #1;
      checks++; if ({stall, done, misalign, bus_err, bus_valid, bus_we} !== 6'b0) begin errors++; $display("FAIL mid_req_ctrl: got %b expected 000000", {stall, done, misalign, bus_err, bus_valid, bus_we}); end
      checks++; if ({bus_addr, bus_be, bus_wdata, ld_data} !== 100'b0) begin errors++; $display("FAIL mid_req_data: got %h/%h/%h/%h expected zeros", bus_addr, bus_be, bus_wdata, ld_data); end
      @(negedge clk); rst_n = 1;
      next_cycle();
      @(negedge clk);
      checks++; if ({bus_valid, stall} !== 2'b00) begin errors++; $display("FAIL post_reset_idle: got %b expected 00", {bus_valid, stall}); end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_byte_load();
      test_half_and_sb();
      test_misalign();
      test_kill_and_priority();
      test_slow_load();
      test_timeout();
      test_reset_mid_req();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
